// File: rtl/mux8_from_mux4.sv
// Registered 8-to-1 lane selector built from two 4:1 stages and a final 2:1 stage.
// The selected lane is captured into the output register on every rising clock edge.
module mux8_from_mux4 #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*DATA_W-1:0]   a,
    input  logic                  s1,
    input  logic                  s2,
    input  logic                  s3,
    output logic [DATA_W-1:0]     out
);

    logic [DATA_W-1:0] lane [8];
    logic [DATA_W-1:0] lower;
    logic [DATA_W-1:0] upper;
    logic [DATA_W-1:0] selected;
    logic [1:0]        subSel;

    assign subSel = {s2, s3};

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lane[k] = a[k*DATA_W +: DATA_W];
        end
    end

    // Both 4:1 stages share the low select bits; each decodes every value.
    always_comb begin
        lower = '0;
        upper = '0;
        case (subSel)
            2'd0: begin lower = lane[0]; upper = lane[4]; end
            2'd1: begin lower = lane[1]; upper = lane[5]; end
            2'd2: begin lower = lane[2]; upper = lane[6]; end
            2'd3: begin lower = lane[3]; upper = lane[7]; end
            default: begin lower = '0; upper = '0; end
        endcase
    end

    assign selected = s1 ? upper : lower;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= selected;
        end
    end

endmodule

// File: tb/tb_mux8_from_mux4.sv
// Self-checking bench for mux8_from_mux4: directed scenarios plus randomized traffic
// on a 1-bit-lane and a 4-bit-lane instance, checked against a shift-based lane model.
module tb_mux8_from_mux4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a1;
    logic [2:0]  sel1;
    logic [0:0]  out1;
    logic [31:0] a4;
    logic [2:0]  sel4;
    logic [3:0]  out4;

    int checks;
    int failures;

    mux8_from_mux4 #(.DATA_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .s1    (sel1[2]),
        .s2    (sel1[1]),
        .s3    (sel1[0]),
        .out   (out1)
    );

    mux8_from_mux4 #(.DATA_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a4),
        .s1    (sel4[2]),
        .s2    (sel4[1]),
        .s3    (sel4[0]),
        .out   (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane sel of a packed bus holding 8 lanes of width w.
    function automatic logic [31:0] pick(input logic [31:0] bus, input int w, input int sel);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (bus >> (sel * w)) & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1    = 8'hFF;
        sel1  = 3'd7;
        a4    = 32'hFFFF_FFFF;
        sel4  = 3'd7;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out1 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold1 cycle %0d: got %0h expected 0", i, out1);
            end
            checks++;
            if (out4 !== 4'h0) begin
                failures++;
                $display("[TB] FAIL reset_hold4 cycle %0d: got %0h expected 0", i, out4);
            end
            tick();
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_first_edge: got %0h expected 1", out1);
        end
        checks++;
        if (out4 !== 4'hF) begin
            failures++;
            $display("[TB] FAIL reset_first_edge4: got %0h expected f", out4);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async: got %0h expected 0", out1);
        end
        tick();
        checks++;
        if (out1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async_hold: got %0h expected 0", out1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_exhaustive();
        logic [0:0] exp;
        a1 = 8'b1100_1101;
        for (int s = 0; s < 8; s++) begin
            sel1 = 3'(s);
            tick();
            exp = pick({24'd0, a1}, 1, s);
            checks++;
            if (out1 !== exp) begin
                failures++;
                $display("[TB] FAIL exhaustive sel=%0d: got %0h expected %0h", s, out1, exp);
            end
        end
    endtask

    task automatic test_onehot();
        logic [0:0] exp;
        for (int k = 0; k < 8; k++) begin
            a1 = 8'd1 << k;
            for (int s = 0; s < 8; s++) begin
                sel1 = 3'(s);
                tick();
                exp = (s == k) ? 1'b1 : 1'b0;
                checks++;
                if (out1 !== exp) begin
                    failures++;
                    $display("[TB] FAIL onehot k=%0d sel=%0d: got %0h expected %0h", k, s, out1, exp);
                end
            end
        end
    endtask

    task automatic test_latency_hold();
        a1   = 8'b0010_0001;
        sel1 = 3'd0;
        tick();
        #2;
        sel1 = 3'd5;
        #1;
        checks++;
        if (out1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_before_edge: got %0h expected 1", out1);
        end
        tick();
        checks++;
        if (out1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_lane5: got %0h expected 1", out1);
        end
        sel1 = 3'd3;
        #2;
        checks++;
        if (out1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_before_edge: got %0h expected 1", out1);
        end
        tick();
        checks++;
        if (out1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_lane3: got %0h expected 0", out1);
        end
        #1 sel1 = 3'd0;
        #2 sel1 = 3'd5;
        #2 sel1 = 3'd3;
        checks++;
        if (out1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_between_edges: got %0h expected 0", out1);
        end
        tick();
        checks++;
        if (out1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_after_edge: got %0h expected 0", out1);
        end
    endtask

    task automatic test_simultaneous();
        a1   = 8'h0F;
        sel1 = 3'd2;
        tick();
        checks++;
        if (out1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL simul_setup: got %0h expected 1", out1);
        end
        a1   = 8'hF0;
        sel1 = 3'd6;
        tick();
        checks++;
        if (out1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL simul_new_lane: got %0h expected 1", out1);
        end
        sel1 = 3'd2;
        tick();
        checks++;
        if (out1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_old_lane: got %0h expected 0", out1);
        end
    endtask

    task automatic test_wide();
        logic [3:0] exp;
        a4 = 32'h7654_3210;
        for (int s = 0; s < 8; s++) begin
            sel4 = 3'(s);
            tick();
            exp = 4'(pick(a4, 4, s));
            checks++;
            if (out4 !== exp) begin
                failures++;
                $display("[TB] FAIL wide sel=%0d: got %0h expected %0h", s, out4, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [0:0] exp1;
        logic [3:0] exp4;
        bit         inReset;
        for (int i = 0; i < 300; i++) begin
            a1   = 8'($urandom);
            sel1 = 3'($urandom_range(0, 7));
            a4   = $urandom;
            sel4 = 3'($urandom_range(0, 7));
            inReset = ($urandom_range(0, 19) == 0);
            rst_n = inReset ? 1'b0 : 1'b1;
            tick();
            exp1 = inReset ? 1'b0 : 1'(pick({24'd0, a1}, 1, int'(sel1)));
            exp4 = inReset ? 4'h0 : 4'(pick(a4, 4, int'(sel4)));
            checks++;
            if (out1 !== exp1) begin
                failures++;
                $display("[TB] FAIL random1 iter %0d a=%0h sel=%0d: got %0h expected %0h",
                         i, a1, sel1, out1, exp1);
            end
            checks++;
            if (out4 !== exp4) begin
                failures++;
                $display("[TB] FAIL random4 iter %0d a=%0h sel=%0d: got %0h expected %0h",
                         i, a4, sel4, out4, exp4);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        a1       = '0;
        sel1     = '0;
        a4       = '0;
        sel4     = '0;
        $display("[TB] starting mux8_from_mux4 bench");
        test_reset();
        test_exhaustive();
        test_onehot();
        test_latency_hold();
        test_simultaneous();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
